// File: rtl/signed_accumulator_register_if.sv
// rtl/signed_accumulator_register_if.sv - command/status bundle for the signed accumulator register
interface signed_accumulator_register_if #(
    parameter int N = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [N-1:0] data_in;
    logic         ser_in;
    logic [N-1:0] q;
    logic         zero;
    logic         ovf;
    logic         busy;
    logic         done;

    modport master (
        output cmd_valid, cmd_op, data_in, ser_in,
        input  cmd_ready, q, zero, ovf, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, data_in, ser_in,
        output cmd_ready, q, zero, ovf, busy, done
    );
endinterface

// File: rtl/signed_accumulator_register.sv
// rtl/signed_accumulator_register.sv - N-bit signed working register with flags and serial load
module signed_accumulator_register #(
    parameter int N = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    signed_accumulator_register_if.slave  bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_CLEAR  = 4'd2;
    localparam logic [3:0] OP_INC    = 4'd3;
    localparam logic [3:0] OP_DEC    = 4'd4;
    localparam logic [3:0] OP_ADD    = 4'd5;
    localparam logic [3:0] OP_SHL    = 4'd6;
    localparam logic [3:0] OP_SHR    = 4'd7;
    localparam logic [3:0] OP_SERIAL = 4'd8;

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [N-1:0]  q_r;
    logic          ovf_r;
    logic          busy_r;
    logic          done_r;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sum;
    logic          add_ovf;

    // Adder result and signed overflow: equal operand signs, differing result sign
    always_comb begin
        sum     = q_r + bus.data_in;
        add_ovf = (q_r[N-1] == bus.data_in[N-1]) && (sum[N-1] != q_r[N-1]);
    end

    // Command execution and serial-load sequencing; busy/done are registered with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q_r    <= '0;
            ovf_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cnt    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            OP_LOAD: begin
                                q_r   <= bus.data_in;
                                ovf_r <= 1'b0;
                            end
                            OP_CLEAR: begin
                                q_r   <= '0;
                                ovf_r <= 1'b0;
                            end
                            OP_INC: begin
                                q_r <= q_r + 1'b1;
                                if (q_r == MAX_POS) ovf_r <= 1'b1;
                            end
                            OP_DEC: begin
                                q_r <= q_r - 1'b1;
                                if (q_r == MIN_NEG) ovf_r <= 1'b1;
                            end
                            OP_ADD: begin
                                q_r <= sum;
                                if (add_ovf) ovf_r <= 1'b1;
                            end
                            OP_SHL: begin
                                q_r <= {q_r[N-2:0], 1'b0};
                                if (q_r[N-1] != q_r[N-2]) ovf_r <= 1'b1;
                            end
                            OP_SHR: begin
                                q_r <= {q_r[N-1], q_r[N-1:1]};
                            end
                            OP_SERIAL: begin
                                ovf_r  <= 1'b0;
                                cnt    <= '0;
                                busy_r <= 1'b1;
                                state  <= SHIFT;
                            end
                            default: ;
                        endcase
                    end
                end
                SHIFT: begin
                    // Commands arriving here are dropped; cmd_ready is low
                    q_r <= {q_r[N-2:0], bus.ser_in};
                    if (cnt == CW'(N - 1)) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.q         = q_r;
    assign bus.zero      = (q_r == '0);
    assign bus.ovf       = ovf_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.cmd_ready = ~busy_r;
endmodule

// File: tb/tb_signed_accumulator_register.sv
// tb/tb_signed_accumulator_register.sv - scoreboard bench for signed_accumulator_register
module tb_signed_accumulator_register;
    localparam int N = 8;

    localparam logic [3:0] NOP = 4'd0, LOAD = 4'd1, CLEAR = 4'd2, INC = 4'd3, DEC = 4'd4;
    localparam logic [3:0] ADD = 4'd5, SHL = 4'd6, SHR = 4'd7, SERIAL = 4'd8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    signed_accumulator_register_if #(.N(N)) bus ();
    signed_accumulator_register #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] q;
        logic       ovf;
        logic       busy;
        logic       done;
        logic       ready;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    logic [12:0] act_v;
    logic [12:0] exp_v;

    // Posedge counter used to tag when each expectation becomes visible
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due in the current cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            total++;
            act_v = {bus.q, bus.ovf, bus.busy, bus.done, bus.cmd_ready, bus.zero};
            exp_v = {mon_e.q, mon_e.ovf, mon_e.busy, mon_e.done, mon_e.ready, mon_e.zero};
            if (mon_e.cyc < cyc)
                $display("FAIL %s: missed sample cycle %0d (now %0d)", mon_e.name, mon_e.cyc, cyc);
            else if (act_v !== exp_v)
                $display("FAIL %s: got q=%h ovf=%b busy=%b done=%b rdy=%b zero=%b, want q=%h ovf=%b busy=%b done=%b rdy=%b zero=%b",
                         mon_e.name, bus.q, bus.ovf, bus.busy, bus.done, bus.cmd_ready, bus.zero,
                         mon_e.q, mon_e.ovf, mon_e.busy, mon_e.done, mon_e.ready, mon_e.zero);
            else
                passed++;
        end
    end

    task automatic tick(input bit r, input bit v, input logic [3:0] op,
                        input logic [7:0] d, input bit s);
        @(negedge clk);
        rst           = r;
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.data_in   = d;
        bus.ser_in    = s;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [7:0] d);
        tick(1'b0, 1'b1, op, d, 1'b0);
    endtask

    task automatic expect_state(input string nm, input logic [7:0] q,
                                input bit ovf, input bit busy, input bit done);
        exp_t e;
        e.cyc   = cyc + 1;
        e.name  = nm;
        e.q     = q;
        e.ovf   = ovf;
        e.busy  = busy;
        e.done  = done;
        e.ready = ~busy;
        e.zero  = (q == 8'h00);
        sb.push_back(e);
    endtask

    logic [7:0] ser_bits;
    logic [7:0] ser_q [8];

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        bus.data_in   = '0;
        bus.ser_in    = 1'b0;
        ser_bits      = 8'b1011_0010;
        ser_q         = '{8'hD5, 8'hAA, 8'h55, 8'hAB, 8'h56, 8'hAC, 8'h59, 8'hB2};

        tick(1'b1, 1'b1, LOAD, 8'h33, 1'b0);
        tick(1'b1, 1'b0, NOP, 8'h00, 1'b0);  expect_state("reset", 8'h00, 0, 0, 0);

        cmd(LOAD, 8'd100);   expect_state("load100", 8'd100, 0, 0, 0);
        cmd(ADD, 8'd27);     expect_state("add27", 8'd127, 0, 0, 0);
        cmd(INC, 8'h00);     expect_state("inc_wrap", 8'h80, 1, 0, 0);
        cmd(DEC, 8'h00);     expect_state("dec_sticky", 8'h7F, 1, 0, 0);
        cmd(CLEAR, 8'h00);   expect_state("clear", 8'h00, 0, 0, 0);
        cmd(DEC, 8'h00);     expect_state("dec_zero", 8'hFF, 0, 0, 0);
        cmd(LOAD, 8'h80);    expect_state("load_min", 8'h80, 0, 0, 0);
        cmd(DEC, 8'h00);     expect_state("dec_wrap", 8'h7F, 1, 0, 0);

        cmd(LOAD, 8'hC0);    expect_state("load_c0", 8'hC0, 0, 0, 0);
        cmd(SHL, 8'h00);     expect_state("shl1", 8'h80, 0, 0, 0);
        cmd(SHL, 8'h00);     expect_state("shl2_ovf", 8'h00, 1, 0, 0);
        cmd(SHR, 8'h00);     expect_state("shr_keeps_ovf", 8'h00, 1, 0, 0);
        cmd(LOAD, 8'h90);    expect_state("load_90", 8'h90, 0, 0, 0);
        cmd(SHR, 8'h00);     expect_state("shr", 8'hC8, 0, 0, 0);
        cmd(LOAD, 8'h9C);    expect_state("load_m100", 8'h9C, 0, 0, 0);
        cmd(ADD, 8'hCE);     expect_state("add_ovf", 8'h6A, 1, 0, 0);

        cmd(SERIAL, 8'h00);  expect_state("ser_accept", 8'h6A, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) tick(1'b0, 1'b1, LOAD, 8'h11, ser_bits[7-i]);
            else        tick(1'b0, 1'b0, NOP, 8'h00, ser_bits[7-i]);
            if (i == 7) expect_state("ser_done", ser_q[i], 0, 0, 1);
            else        expect_state($sformatf("ser_shift%0d", i), ser_q[i], 0, 1, 0);
        end
        cmd(NOP, 8'h00);     expect_state("done_once", 8'hB2, 0, 0, 0);

        cmd(SERIAL, 8'h00);  expect_state("ser2_accept", 8'hB2, 0, 1, 0);
        tick(1'b0, 1'b0, NOP, 8'h00, 1'b1);  expect_state("ser2_s0", 8'h65, 0, 1, 0);
        tick(1'b0, 1'b0, NOP, 8'h00, 1'b1);  expect_state("ser2_s1", 8'hCB, 0, 1, 0);
        tick(1'b0, 1'b0, NOP, 8'h00, 1'b1);  expect_state("ser2_s2", 8'h97, 0, 1, 0);
        tick(1'b1, 1'b0, NOP, 8'h00, 1'b1);  expect_state("ser2_reset", 8'h00, 0, 0, 0);
        cmd(LOAD, 8'h55);    expect_state("load_after_rst", 8'h55, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, NOP, 8'h00, 1'b1);
            expect_state($sformatf("no_done%0d", i), 8'h55, 0, 0, 0);
        end

        cmd(4'hF, 8'h12);    expect_state("undef_f", 8'h55, 0, 0, 0);
        cmd(LOAD, 8'h7F);    expect_state("load_max", 8'h7F, 0, 0, 0);
        cmd(INC, 8'h00);     expect_state("inc_ovf", 8'h80, 1, 0, 0);
        cmd(4'h9, 8'h01);    expect_state("undef_9", 8'h80, 1, 0, 0);
        cmd(NOP, 8'h01);     expect_state("nop", 8'h80, 1, 0, 0);
        cmd(ADD, 8'h7F);     expect_state("add_mixed_sign", 8'hFF, 1, 0, 0);

        tick(1'b0, 1'b0, NOP, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++;
            $display("FAIL %s: never sampled, due cycle %0d now %0d", mon_e.name, mon_e.cyc, cyc);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end
endmodule

// File: doc/signed_accumulator_register.md
Name: signed_accumulator_register

Overview:
- N-bit signed (two's complement) working register.
- Sits directly upstream of the sign-detection stage: its q output drives that stage's number input.
- Executes one command per handshake: load, clear, increment, decrement, add, arithmetic shifts, and a multi-cycle MSB-first serial load.
- Also produces zero and sticky overflow flags for the rest of the datapath.

Parameters:
- N, 8, register width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present this cycle.
- cmd_ready  output  1  block can accept a command. Equals ~busy.
- cmd_op  input  4  opcode: 0 NOP, 1 LOAD, 2 CLEAR, 3 INC, 4 DEC, 5 ADD, 6 SHL, 7 SHR, 8 SERIAL. Codes 9–15 behave as NOP.
- data_in  input  N  signed operand for LOAD and ADD.
- ser_in  input  1  serial data bit for SERIAL.
- q  output  N  signed register contents.
- zero  output  1  1 when q == 0 (combinational from q).
- ovf  output  1  sticky signed-overflow flag.
- busy  output  1  serial load in progress.
- done  output  1  one-cycle pulse when a serial load completes.

Behaviour:
- Reset: when rst=1 at a rising edge:
  - q=0, ovf=0, busy=0, done=0, bit counter=0, state=IDLE.
  - Reset overrides any command or serial load in progress; a partial serial load is discarded.
- Accept rule: a command is accepted at a rising edge where cmd_valid=1 and cmd_ready=1. Its result appears on q in the following cycle (1-cycle latency). cmd_valid while busy=1 is ignored; nothing is queued.
- States:
  - IDLE: busy=0. An accepted SERIAL moves to SHIFT with counter=0. All other accepted opcodes execute at the accept edge and remain in IDLE.
  - SHIFT: busy=1. At each edge, q <= {q[N-2:0], ser_in} and the counter increments. The edge where the counter reaches N-1 performs the N-th shift and returns to IDLE; done=1 in the next cycle only.
  - Total for SERIAL: busy high for exactly N cycles, then done high for 1 cycle coincident with busy=0. A new command may be accepted in the done cycle.
- SERIAL q timing: q is not modified at the SERIAL accept edge. ser_in is sampled on the N edges that follow it. The first sampled bit ends up in q[N-1].
- Arithmetic: all modulo 2^N (wrap-around).
  - LOAD: q <= data_in; ovf <= 0.
  - CLEAR: q <= 0; ovf <= 0.
  - INC: q <= q+1. Sets ovf if q was 2^(N-1)-1 (max → min).
  - DEC: q <= q-1. Sets ovf if q was -2^(N-1) (min → max).
  - ADD: q <= q+data_in. Sets ovf when both operand signs are equal and the result sign differs.
  - SHL: q <= {q[N-2:0],0}. Sets ovf if q[N-1] != q[N-2].
  - SHR: arithmetic shift, q <= {q[N-1], q[N-1:1]}. Never sets ovf.
  - SERIAL: ovf <= 0 at the accept edge.
- ovf is sticky: only LOAD, CLEAR, SERIAL or reset clear it. INC/DEC/ADD/SHL never clear it.
- NOP and undefined opcodes: q and ovf unchanged.
- done is 0 in every cycle except the single cycle following SERIAL completion.

Test Plan:
- Reset/LOAD/ADD: rst held 2 cycles → q=0, zero=1, ovf=0, cmd_ready=1. Then LOAD 8'sd100 → next cycle q=100, zero=0. Then ADD 8'sd27 → q=127, ovf=0.
- Overflow wrap and sticky flag: from q=127, INC → q=-128 (8'h80), ovf=1. Then DEC → q=127 with ovf still 1. Then CLEAR → q=0, ovf=0.
- Shifts and ADD overflow:
  - LOAD 8'hC0, SHL → q=8'h80, ovf=0. SHL again → q=8'h00, ovf=1.
  - LOAD 8'h90, SHR → q=8'hC8.
  - LOAD -100, ADD -50 → q=8'h6A (106), ovf=1.
- Serial load: SERIAL accepted, ser_in driven 1,0,1,1,0,0,1,0 on the next 8 edges → busy=1 for exactly 8 cycles with cmd_ready=0. A LOAD issued mid-sequence is ignored. Then done=1 for one cycle, busy=0, q=8'hB2, ovf=0.
- Reset mid-serial: SERIAL accepted, rst=1 after 3 shifts → next cycle q=0, busy=0, done never pulses. A LOAD in the following cycle is accepted normally.
- Undefined opcode: q=8'h55, cmd_op=4'hF with cmd_valid=1 → q stays 8'h55, ovf unchanged, busy stays 0.
